pbus_master: RTL and testbench
==============================

# pbus_master

Initiator end of the APB-like peripheral bus (pbus) used by the PTPv2 register blocks. It accepts single register-access commands over a valid/ready command port and runs one pbus SETUP/ACCESS transfer per command. It waits for `pbus_ready_i`, with a programmable timeout, and returns read data and error status over a valid/ready response port. It sits between a host-side agent (CPU shim, test sequencer, management port) and the slave-side pbus-to-IP-bus bridge.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum ACCESS-phase cycles to wait for `pbus_ready_i`; 0 disables the timeout.
- `TO_W`, default 8: timeout counter width; must satisfy `TIMEOUT_CYCLES < 2**TO_W`.

Ports:
- `pbus_clk`  in  1  single clock for the whole block.
- `pbus_rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command request.
- `cmd_ready_o`  out  1  block can accept a command.
- `cmd_write_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  32  byte address.
- `cmd_wdata_i`  in  32  write data (ignored for reads).
- `rsp_valid_o`  out  1  response available.
- `rsp_ready_i`  in  1  response consumer ready.
- `rsp_rdata_o`  out  32  read data; 0 for writes and timeouts.
- `rsp_err_o`  out  1  slave error or timeout.
- `rsp_timeout_o`  out  1  transfer aborted by timeout.
- `pbus_addr_o`  out  32  pbus address.
- `pbus_write_o`  out  1  pbus direction.
- `pbus_sel_o`  out  1  pbus select.
- `pbus_enable_o`  out  1  pbus enable (ACCESS phase).
- `pbus_wdata_o`  out  32  pbus write data.
- `pbus_rdata_i`  in  32  pbus read data.
- `pbus_ready_i`  in  1  slave ready.
- `pbus_slverr_i`  in  1  slave error, valid with ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - `cmd_ready_o` = 1.
  - On `cmd_valid_i & cmd_ready_o`: register write, addr and wdata, then go to SETUP.
  - `cmd_ready_o` is 0 in every other state.
- **SETUP**
  - `pbus_sel_o` = 1, `pbus_enable_o` = 0.
  - Address, write and wdata are driven from the registers.
  - Always goes to ACCESS on the next cycle.
- **ACCESS**
  - `pbus_sel_o` = 1, `pbus_enable_o` = 1.
  - Address, write and wdata stay stable.
  - The timeout counter increments each ACCESS cycle without ready.
  - On `pbus_ready_i`: capture `pbus_slverr_i`, and capture `pbus_rdata_i` if the transfer is a read (otherwise load 0). Go to RESP.
  - Otherwise, if `TIMEOUT_CYCLES` ≠ 0 and the counter equals `TIMEOUT_CYCLES`, abort: err = 1, timeout = 1, rdata = 0. Go to RESP.
  - Ready wins over timeout when both occur in the same cycle.
- **RESP**
  - `rsp_valid_o` = 1; response fields are held stable.
  - `pbus_sel_o` = 0, `pbus_enable_o` = 0.
  - On `rsp_ready_i`: go to IDLE and clear the counter.
- Outside SETUP/ACCESS, `pbus_sel_o` and `pbus_enable_o` are 0. Address, write and wdata keep their last value; no requirement on them.
- `rsp_err_o` = captured `slverr` OR timeout.

## Timing
- Reset values (asynchronous, immediate on `pbus_rst_n` low):
  - State is IDLE and the counter is 0.
  - `cmd_ready_o` = 1 once reset has been applied.
  - `rsp_valid_o`, `rsp_err_o`, `rsp_timeout_o`, `pbus_sel_o`, `pbus_enable_o` and `pbus_write_o` = 0.
  - All data and address outputs = 0.
- Latency, measured from the command-accept edge: SETUP in cycle 1, ACCESS starts in cycle 2.
  - With zero-wait slaves, `rsp_valid_o` rises in cycle 3.
  - With N wait states, it rises in cycle 3 + N.
- Throughput: with `rsp_ready_i` held high, one transfer every 4 cycles. A command presented during RESP waits for IDLE.
- Timeout: with `TIMEOUT_CYCLES` = T and `pbus_ready_i` stuck low, ACCESS lasts T + 1 cycles and `rsp_valid_o` rises in cycle 3 + T.
- The ACCESS phase and pbus outputs end on the edge that samples ready. No new SETUP starts before the response is consumed.
- Reset mid-transfer: the transfer is discarded and no response is produced. Bus outputs drop asynchronously.
- `cmd_*` inputs are sampled only at the accept edge; later changes are ignored.

## Structure
- Add to `ptpv2_defines.v`:
  - FSM state encodings (2-bit, IDLE = 0).
  - Default timeout value.
  - pbus address/data width macros (32).
- No sub-module is required. The timeout counter stays inline in `pbus_master`.
- Integration: instantiate back-to-back with the slave-side bridge for loopback tests of the register map.

## Test plan
- **Zero-wait write:** cmd write, addr 0x0000_0040, wdata 0x0000_1234, slave ready tied high.
  - SETUP at cycle 1, ACCESS at cycle 2 with addr/wdata on the bus.
  - `rsp_valid` at cycle 3 with err = 0, timeout = 0, rdata = 0.
- **Wait-state read:** read addr 0x0000_0010, slave holds ready low for 3 ACCESS cycles then returns 0xCAFE_0001.
  - `enable` high for 4 cycles.
  - `rsp_rdata` = 0xCAFE_0001 at cycle 6.
- **Slave error:** slave returns ready = 1 with slverr = 1 on a write.
  - `rsp_err` = 1, `rsp_timeout` = 0.
- **Timeout:** `TIMEOUT_CYCLES` = 4, ready stuck low.
  - ACCESS lasts 5 cycles.
  - Response at cycle 7 with err = 1, timeout = 1, rdata = 0; `sel`/`enable` drop on that edge.
- **Backpressure:** `rsp_ready` low for 5 cycles after `rsp_valid`, with a second command pending.
  - Response is held stable and `cmd_ready` stays 0.
  - The second command is accepted on the cycle after `rsp_ready` goes high.
- **Reset mid-ACCESS:** assert `pbus_rst_n` low while `enable` = 1.
  - Outputs go to reset values immediately.
  - After release, no spurious `rsp_valid`, and `cmd_ready` = 1.

Source files
------------

// File: rtl/pbus_master_pkg.sv
// Shared definitions for the pbus initiator: bus widths, default timeout,
// FSM state encoding and the captured-response record.
package pbus_master_pkg;

  localparam int unsigned PBUS_AW              = 32;
  localparam int unsigned PBUS_DW              = 32;
  localparam int unsigned PBUS_TIMEOUT_DEFAULT = 255;

  // Transfer sequencing; IDLE must stay at encoding 0 so reset lands there.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } pbus_state_e;

  // Outcome of one transfer, held unchanged while the response is offered.
  typedef struct packed {
    logic [PBUS_DW-1:0] rdata;
    logic               slverr;
    logic               timeout;
  } pbus_rsp_t;

endpackage

// File: rtl/pbus_master.sv
// pbus initiator: takes one register command at a time, runs a SETUP/ACCESS
// transfer on the peripheral bus, waits for ready (with optional timeout) and
// offers the read data / error status on a valid/ready response port.
module pbus_master
  import pbus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PBUS_TIMEOUT_DEFAULT,
  parameter int unsigned TO_W           = 8
) (
  input  logic               pbus_clk,
  input  logic               pbus_rst_n,
  // command port
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_write_i,
  input  logic [PBUS_AW-1:0] cmd_addr_i,
  input  logic [PBUS_DW-1:0] cmd_wdata_i,
  // response port
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [PBUS_DW-1:0] rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               rsp_timeout_o,
  // pbus
  output logic [PBUS_AW-1:0] pbus_addr_o,
  output logic               pbus_write_o,
  output logic               pbus_sel_o,
  output logic               pbus_enable_o,
  output logic [PBUS_DW-1:0] pbus_wdata_o,
  input  logic [PBUS_DW-1:0] pbus_rdata_i,
  input  logic               pbus_ready_i,
  input  logic               pbus_slverr_i
);

  // A zero limit means "wait forever"; the compare is then never armed.
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
  localparam bit              TO_ENABLE = (TIMEOUT_CYCLES != 0);

  pbus_state_e        r_state;
  pbus_state_e        w_state_nxt;
  logic               r_write;
  logic [PBUS_AW-1:0] r_addr;
  logic [PBUS_DW-1:0] r_wdata;
  pbus_rsp_t          r_rsp;
  logic [TO_W-1:0]    r_cnt;

  logic w_accept;
  logic w_done;
  logic w_expire;

  // Next-state decode plus the state-derived handshake and bus strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_done        = 1'b0;
    w_expire      = 1'b0;
    cmd_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    pbus_sel_o    = 1'b0;
    pbus_enable_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        pbus_sel_o  = 1'b1;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        pbus_sel_o    = 1'b1;
        pbus_enable_o = 1'b1;
        // Ready is checked first so a late slave still wins on the limit cycle.
        if (pbus_ready_i) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (TO_ENABLE && (r_cnt == TO_LIMIT)) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; an asynchronous reset abandons any transfer in flight.
  always_ff @(posedge pbus_clk or negedge pbus_rst_n) begin
    // NOTE: sequential state is always updated with <= so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!pbus_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command capture at the accept edge; bus drives from these until the next accept.
  always_ff @(posedge pbus_clk or negedge pbus_rst_n) begin
    // NOTE: the address/data registers are reset as well, because they drive
    // bus pins that must read 0 straight out of reset.
    if (!pbus_rst_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= cmd_write_i;
      r_addr  <= cmd_addr_i;
      r_wdata <= cmd_wdata_i;
    end
  end

  // Response capture: slave result on ready, forced error on timeout, cleared on accept.
  always_ff @(posedge pbus_clk or negedge pbus_rst_n) begin
    if (!pbus_rst_n) begin
      r_rsp <= '0;
    end else if (w_accept) begin
      r_rsp <= '0;
    end else if (w_done) begin
      r_rsp.rdata   <= r_write ? '0 : pbus_rdata_i;
      r_rsp.slverr  <= pbus_slverr_i;
      r_rsp.timeout <= 1'b0;
    end else if (w_expire) begin
      r_rsp.rdata   <= '0;
      r_rsp.slverr  <= 1'b0;
      r_rsp.timeout <= 1'b1;
    end
  end

  // Wait-state counter: counts ACCESS cycles without ready, cleared when the response is taken.
  always_ff @(posedge pbus_clk or negedge pbus_rst_n) begin
    if (!pbus_rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == ST_ACCESS) && !pbus_ready_i) begin
      r_cnt <= r_cnt + TO_W'(1);
    end else if ((r_state == ST_RESP) && rsp_ready_i) begin
      r_cnt <= '0;
    end
  end

  assign pbus_addr_o   = r_addr;
  assign pbus_write_o  = r_write;
  assign pbus_wdata_o  = r_wdata;
  assign rsp_rdata_o   = r_rsp.rdata;
  assign rsp_timeout_o = r_rsp.timeout;
  assign rsp_err_o     = r_rsp.slverr | r_rsp.timeout;

endmodule

// File: tb/tb_pbus_master.sv
// Bench for pbus_master: directed commands against a behavioural pbus slave,
// expected responses queued at issue time and checked by a separate monitor.
module tb_pbus_master;

  logic        pbus_clk      = 1'b0;
  logic        pbus_rst_n    = 1'b1;
  logic        cmd_valid_i   = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i   = 1'b0;
  logic [31:0] cmd_addr_i    = '0;
  logic [31:0] cmd_wdata_i   = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i   = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [31:0] pbus_addr_o;
  logic        pbus_write_o;
  logic        pbus_sel_o;
  logic        pbus_enable_o;
  logic [31:0] pbus_wdata_o;
  logic [31:0] pbus_rdata_i  = '0;
  logic        pbus_ready_i  = 1'b0;
  logic        pbus_slverr_i = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // slave behaviour, set by the stimulus before each command
  int          slv_waits = 0;
  bit          slv_stuck = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err   = 1'b0;
  int          slv_acc   = 0;

  pbus_master #(
    .TIMEOUT_CYCLES(4),
    .TO_W          (8)
  ) dut (
    .pbus_clk     (pbus_clk),
    .pbus_rst_n   (pbus_rst_n),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .pbus_addr_o  (pbus_addr_o),
    .pbus_write_o (pbus_write_o),
    .pbus_sel_o   (pbus_sel_o),
    .pbus_enable_o(pbus_enable_o),
    .pbus_wdata_o (pbus_wdata_o),
    .pbus_rdata_i (pbus_rdata_i),
    .pbus_ready_i (pbus_ready_i),
    .pbus_slverr_i(pbus_slverr_i)
  );

  always #5 pbus_clk = ~pbus_clk;

  always @(posedge pbus_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: ready after slv_waits extra ACCESS cycles (never if stuck);
  // rdata/slverr carry junk whenever ready is low.
  always begin
    @(posedge pbus_clk);
    #1;
    if (pbus_sel_o && pbus_enable_o) begin
      if (!slv_stuck && slv_acc == slv_waits) begin
        pbus_ready_i  = 1'b1;
        pbus_rdata_i  = slv_rdata;
        pbus_slverr_i = slv_err;
      end else begin
        pbus_ready_i  = 1'b0;
        pbus_rdata_i  = 32'hDEAD_BEEF;
        pbus_slverr_i = 1'b1;
      end
      slv_acc++;
    end else begin
      pbus_ready_i  = 1'b0;
      pbus_rdata_i  = 32'hDEAD_BEEF;
      pbus_slverr_i = 1'b0;
      slv_acc       = 0;
    end
  end

  // Monitor: every accepted response is compared with the oldest expectation.
  always @(negedge pbus_clk) begin
    if (pbus_rst_n && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'b0, rsp_valid_o}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata_o, mon_e.rdata);
        check("rsp_err", {31'b0, rsp_err_o}, {31'b0, mon_e.err});
        check("rsp_timeout", {31'b0, rsp_timeout_o}, {31'b0, mon_e.to});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'b0, cmd_ready_o}, 32'd1);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid_o}, 32'd0);
    check({tag, "_rsp_err"}, {31'b0, rsp_err_o}, 32'd0);
    check({tag, "_rsp_timeout"}, {31'b0, rsp_timeout_o}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
    check({tag, "_sel"}, {31'b0, pbus_sel_o}, 32'd0);
    check({tag, "_enable"}, {31'b0, pbus_enable_o}, 32'd0);
    check({tag, "_write"}, {31'b0, pbus_write_o}, 32'd0);
    check({tag, "_addr"}, pbus_addr_o, 32'd0);
    check({tag, "_wdata"}, pbus_wdata_o, 32'd0);
  endtask

  // Issues one command (called at posedge+1 with the DUT idle), follows it
  // through SETUP/ACCESS and returns at the negedge of the first RESP cycle.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input bit stuck, input logic [31:0] srd, input logic serr,
                      input logic [31:0] e_rdata, input logic e_err, input logic e_to,
                      input int e_lat, output int acc_cyc);
    exp_t e;
    int   lat;
    int   en_cnt;
    bit   done;
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    slv_waits   = waits;
    slv_stuck   = stuck;
    slv_rdata   = srd;
    slv_err     = serr;
    e.rdata = e_rdata;
    e.err   = e_err;
    e.to    = e_to;
    exp_q.push_back(e);
    @(negedge pbus_clk);
    check("cmd_ready_idle", {31'b0, cmd_ready_o}, 32'd1);
    @(posedge pbus_clk);
    #1;
    acc_cyc = cyc;
    // later command changes must not reach the bus
    cmd_valid_i = 1'b0;
    cmd_write_i = ~wr;
    cmd_addr_i  = ~addr;
    cmd_wdata_i = ~wdata;
    @(negedge pbus_clk);
    check("setup_sel", {31'b0, pbus_sel_o}, 32'd1);
    check("setup_enable", {31'b0, pbus_enable_o}, 32'd0);
    check("setup_addr", pbus_addr_o, addr);
    check("setup_wdata", pbus_wdata_o, wdata);
    check("setup_write", {31'b0, pbus_write_o}, {31'b0, wr});
    check("setup_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
    lat    = 1;
    en_cnt = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge pbus_clk);
      lat++;
      if (rsp_valid_o) begin
        done = 1'b1;
      end else if (lat > 40) begin
        check("rsp_wait_bound", {31'b0, rsp_valid_o}, 32'd1);
        done = 1'b1;
      end else begin
        check("access_sel", {31'b0, pbus_sel_o}, 32'd1);
        check("access_enable", {31'b0, pbus_enable_o}, 32'd1);
        check("access_addr", pbus_addr_o, addr);
        check("access_wdata", pbus_wdata_o, wdata);
        check("access_write", {31'b0, pbus_write_o}, {31'b0, wr});
        en_cnt++;
      end
    end
    check("rsp_latency", 32'(lat), 32'(e_lat));
    check("access_cycles", 32'(en_cnt), 32'(e_lat - 2));
    check("resp_sel", {31'b0, pbus_sel_o}, 32'd0);
    check("resp_enable", {31'b0, pbus_enable_o}, 32'd0);
    check("resp_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
  endtask

  task automatic consume();
    @(posedge pbus_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    int a1;

    // reset values
    #3 pbus_rst_n = 1'b0;
    #4;
    check_reset_outputs("reset");
    @(posedge pbus_clk);
    #1;
    @(posedge pbus_clk);
    #1;
    pbus_rst_n = 1'b1;
    @(posedge pbus_clk);
    #1;

    // zero-wait write: response in cycle 3, rdata forced to 0
    send(1'b1, 32'h0000_0040, 32'h0000_1234, 0, 1'b0, 32'h5555_AAAA, 1'b0,
         32'h0, 1'b0, 1'b0, 3, a0);
    consume();
    // read with 3 wait states: enable for 4 cycles, data in cycle 6
    send(1'b0, 32'h0000_0010, 32'hFFFF_0000, 3, 1'b0, 32'hCAFE_0001, 1'b0,
         32'hCAFE_0001, 1'b0, 1'b0, 6, a0);
    consume();
    // slave error on a write
    send(1'b1, 32'h0000_0044, 32'hA5A5_0F0F, 1, 1'b0, 32'h1111_2222, 1'b1,
         32'h0, 1'b1, 1'b0, 4, a0);
    consume();
    // slave error on a read still returns the read data
    send(1'b0, 32'h0000_0080, 32'h0000_0000, 0, 1'b0, 32'h1357_9BDF, 1'b1,
         32'h1357_9BDF, 1'b1, 1'b0, 3, a0);
    consume();
    // timeout with limit 4: 5 ACCESS cycles, response in cycle 7
    send(1'b0, 32'h0000_0020, 32'h0000_0000, 0, 1'b1, 32'h7777_7777, 1'b0,
         32'h0, 1'b1, 1'b1, 7, a0);
    consume();
    // ready on the limit cycle wins over the timeout
    send(1'b0, 32'h0000_0024, 32'h0000_0000, 4, 1'b0, 32'h0BAD_F00D, 1'b0,
         32'h0BAD_F00D, 1'b0, 1'b0, 7, a0);
    consume();

    // back-to-back zero-wait transfers: one accept every 4 cycles
    send(1'b0, 32'h0000_0100, 32'h0000_0000, 0, 1'b0, 32'h0102_0304, 1'b0,
         32'h0102_0304, 1'b0, 1'b0, 3, a0);
    consume();
    send(1'b1, 32'h0000_0104, 32'hFACE_B00C, 0, 1'b0, 32'h0, 1'b0,
         32'h0, 1'b0, 1'b0, 3, a1);
    consume();
    check("throughput_cycles", 32'(a1 - a0), 32'd4);

    // backpressure: response held for 5 cycles with a second command waiting
    rsp_ready_i = 1'b0;
    send(1'b0, 32'h0000_0060, 32'h0000_0000, 0, 1'b0, 32'h0000_BEEF, 1'b0,
         32'h0000_BEEF, 1'b0, 1'b0, 3, a0);
    for (int i = 0; i < 4; i++) begin
      @(posedge pbus_clk);
      #1;
      if (i == 0) begin
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 32'h0000_0064;
        cmd_wdata_i = 32'h0;
      end
      @(negedge pbus_clk);
      check("bp_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata_o, 32'h0000_BEEF);
      check("bp_rsp_err", {31'b0, rsp_err_o}, 32'd0);
      check("bp_rsp_timeout", {31'b0, rsp_timeout_o}, 32'd0);
      check("bp_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
    end
    @(posedge pbus_clk);
    #1;
    rsp_ready_i = 1'b1;
    @(negedge pbus_clk);
    check("bp_cmd_ready_handshake", {31'b0, cmd_ready_o}, 32'd0);
    @(posedge pbus_clk);
    #1;
    send(1'b0, 32'h0000_0064, 32'h0000_0000, 0, 1'b0, 32'h600D_CAFE, 1'b0,
         32'h600D_CAFE, 1'b0, 1'b0, 3, a1);
    consume();
    check("bp_accept_cycles", 32'(a1 - a0), 32'd9);

    // reset in the middle of ACCESS: transfer discarded, no response
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b1;
    cmd_addr_i  = 32'h0000_0ABC;
    cmd_wdata_i = 32'h1234_5678;
    slv_stuck   = 1'b1;
    @(posedge pbus_clk);
    #1;
    cmd_valid_i = 1'b0;
    @(posedge pbus_clk);
    #1;
    @(negedge pbus_clk);
    check("rst_pre_enable", {31'b0, pbus_enable_o}, 32'd1);
    #1 pbus_rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge pbus_clk);
    #1;
    pbus_rst_n = 1'b1;
    slv_stuck  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge pbus_clk);
      check("post_rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
      check("post_rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    end
    @(posedge pbus_clk);
    #1;
    send(1'b0, 32'h0000_000C, 32'h0000_0000, 0, 1'b0, 32'h4242_4242, 1'b0,
         32'h4242_4242, 1'b0, 1'b0, 3, a0);
    consume();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
